// File: rtl/rv32_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// rv32_seq_ctrl_if
//   Shared memory bus between the RV32 sequencer and the memory system.
//   One request at a time. A request is held until mem_ready.
//
//   Signals
//     mem_valid  request present
//     mem_instr  request is an instruction fetch
//     mem_addr   byte address
//     mem_wdata  write data
//     mem_wstrb  byte write strobes (0 = read)
//     mem_ready  memory accepts / returns data this cycle
//     mem_rdata  read data, valid with mem_ready
//
//   Modports
//     master  sequencer side (drives the request, receives the response)
//     slave   memory side
// ----------------------------------------------------------------------------
interface rv32_seq_ctrl_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/rv32_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rv32_seq_ctrl
//   Sequencer around a combinational RV32I core. Owns the PC and the
//   instruction register. Time-shares one memory port between instruction
//   fetch and the core's single data access per instruction. Commits the PC
//   when the core reports completion and stops for good on a trap or on a
//   misaligned PC (only reset restarts it).
//
//   Parameters
//     PROGADDR_RESET  PC loaded on reset
//     TIME_DIV        csr_time advances once every TIME_DIV cycles (0 acts as 1)
//     CYCLE_INIT      reset value of csr_cycle (normally 0; a non-zero value
//                     lets the wrap of the 64-bit counter be observed quickly)
//
//   Build option
//     RV32_SEQ_COUNTERS_EN  when defined, csr_cycle/csr_time/csr_instret are
//                           real counters; when undefined they are constant 0
//                           and their registers do not exist.
//
//   Ports
//     clk, reset           clock; asynchronous active-high reset
//     bus                  memory bus (master side)
//     core_pc              current PC to the core
//     core_insn            latched instruction word
//     core_insn_valid      core_insn is being executed (EXEC state)
//     core_insn_complete   core has finished the current instruction
//     core_pc_next         PC to commit on completion
//     core_trap            core raised a trap
//     core_mem_valid/addr/wdata/wstrb  core data request
//     core_mem_ready       core data access done
//     core_mem_rdata       core data read value
//     csr_cycle/csr_time/csr_instret   64-bit counters to the core
//     halted               sequencer stopped
// ----------------------------------------------------------------------------
module rv32_seq_ctrl #(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
    parameter logic [15:0] TIME_DIV       = 16'd1,
    parameter logic [63:0] CYCLE_INIT     = 64'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    rv32_seq_ctrl_if.master        bus,
    output logic [31:0]            core_pc,
    output logic [31:0]            core_insn,
    output logic                   core_insn_valid,
    input  logic                   core_insn_complete,
    input  logic [31:0]            core_pc_next,
    input  logic                   core_trap,
    input  logic                   core_mem_valid,
    input  logic [31:0]            core_mem_addr,
    input  logic [31:0]            core_mem_wdata,
    input  logic [3:0]             core_mem_wstrb,
    output logic                   core_mem_ready,
    output logic [31:0]            core_mem_rdata,
    output logic [63:0]            csr_cycle,
    output logic [63:0]            csr_time,
    output logic [63:0]            csr_instret,
    output logic                   halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] insn_q;
    logic        dmem_done_q;   // data access of this instruction already finished
    logic [31:0] dmem_rdata_q;  // read data captured when the access finished early

    logic pc_misaligned;
    logic fetch_accept;
    logic data_accept;
    logic commit;

    assign pc_misaligned = |pc_q[1:0];

    // Instruction word arrives.
    assign fetch_accept = (state_q == S_FETCH) && !pc_misaligned && bus.mem_ready;

    // Data access finishes while the core still needs more cycles: remember
    // the result so the bus is released and the access is never reissued.
    assign data_accept = (state_q == S_EXEC) && !core_trap && !dmem_done_q &&
                         core_mem_valid && bus.mem_ready && !core_insn_complete;

    // A trap in the same cycle as completion wins: nothing is committed.
    assign commit = (state_q == S_EXEC) && !core_trap && core_insn_complete;

    // ------------------------------------------------------------------------
    // Next state and bus/core outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d         = state_q;
        bus.mem_valid   = 1'b0;
        bus.mem_instr   = 1'b0;
        bus.mem_addr    = 32'd0;
        bus.mem_wdata   = 32'd0;
        bus.mem_wstrb   = 4'd0;
        core_insn_valid = 1'b0;
        core_mem_ready  = 1'b0;
        core_mem_rdata  = 32'd0;

        // Outputs are gated by reset itself so the bus is quiet for the whole
        // time reset is held, not only from the first clock edge.
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    if (pc_misaligned) begin
                        state_d = S_HALT;
                    end else begin
                        bus.mem_valid = 1'b1;
                        bus.mem_instr = 1'b1;
                        bus.mem_addr  = pc_q;
                        if (bus.mem_ready) begin
                            state_d = S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    core_insn_valid = 1'b1;
                    if (core_trap) begin
                        state_d = S_HALT;
                    end else begin
                        if (core_mem_valid) begin
                            if (dmem_done_q) begin
                                core_mem_ready = 1'b1;
                                core_mem_rdata = dmem_rdata_q;
                            end else begin
                                bus.mem_valid  = 1'b1;
                                bus.mem_addr   = core_mem_addr;
                                bus.mem_wdata  = core_mem_wdata;
                                bus.mem_wstrb  = core_mem_wstrb;
                                core_mem_ready = bus.mem_ready;
                                core_mem_rdata = bus.mem_rdata;
                            end
                        end
                        if (core_insn_complete) begin
                            state_d = S_FETCH;
                        end
                    end
                end

                default: begin
                    // S_HALT: everything stays at its default until reset.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State, PC, instruction register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignments so each one samples the
        // values from before the edge regardless of statement order.
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= PROGADDR_RESET;
            insn_q      <= 32'd0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fetch_accept) begin
                insn_q <= bus.mem_rdata;
            end
            if (commit) begin
                pc_q        <= core_pc_next;
                dmem_done_q <= 1'b0;
            end else if (data_accept) begin
                dmem_done_q <= 1'b1;
            end
        end
    end

    // NOTE: dmem_rdata_q is a pure data register that is only looked at while
    // dmem_done_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (data_accept) begin
            dmem_rdata_q <= bus.mem_rdata;
        end
    end

    assign core_pc   = pc_q;
    assign core_insn = insn_q;
    assign halted    = (state_q == S_HALT);

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
`ifdef RV32_SEQ_COUNTERS_EN
    localparam logic [15:0] TIME_DIV_EFF = (TIME_DIV == 16'd0) ? 16'd1 : TIME_DIV;

    logic [63:0] cycle_q;
    logic [63:0] time_q;
    logic [63:0] instret_q;
    logic [15:0] prescale_q;

    // All counters wrap naturally at 2^64. The core reads the registered
    // values, so an instruction committing in this cycle sees the old count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q    <= CYCLE_INIT;
            time_q     <= 64'd0;
            instret_q  <= 64'd0;
            prescale_q <= 16'd0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (prescale_q >= TIME_DIV_EFF - 16'd1) begin
                prescale_q <= 16'd0;
                time_q     <= time_q + 64'd1;
            end else begin
                prescale_q <= prescale_q + 16'd1;
            end
            if (commit) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    assign csr_cycle   = cycle_q;
    assign csr_time    = time_q;
    assign csr_instret = instret_q;
`else
    // Counters compiled out: constant zero. The parameters are still
    // referenced so both builds accept the same parameter list.
    assign csr_cycle   = CYCLE_INIT & 64'd0;
    assign csr_time    = {48'd0, TIME_DIV & 16'd0};
    assign csr_instret = 64'd0;
`endif

endmodule

// File: tb/tb_rv32_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rv32_seq_ctrl
//   Plays both the RV32 core and the memory around rv32_seq_ctrl. Each
//   instruction is described as a transaction (fetch latency, optional data
//   access with its latency, extra cycles the core needs, trap, next PC).
//   A directed table, a few hand-written sequences and random transactions
//   are applied; expectations come from a small architectural model
//   (PC, retired count, halt flag, elapsed cycles).
// ----------------------------------------------------------------------------
module tb_rv32_seq_ctrl;

    localparam logic [31:0] PC0  = 32'h0000_0100;
    localparam logic [63:0] CYC0 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          TDIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] core_pc;
    logic [31:0] core_insn;
    logic        core_insn_valid;
    logic        core_insn_complete;
    logic [31:0] core_pc_next;
    logic        core_trap;
    logic        core_mem_valid;
    logic [31:0] core_mem_addr;
    logic [31:0] core_mem_wdata;
    logic [3:0]  core_mem_wstrb;
    logic        core_mem_ready;
    logic [31:0] core_mem_rdata;
    logic [63:0] csr_cycle;
    logic [63:0] csr_time;
    logic [63:0] csr_instret;
    logic        halted;

    always #5 clk = ~clk;

    rv32_seq_ctrl_if bus ();

    rv32_seq_ctrl #(
        .PROGADDR_RESET (PC0),
        .TIME_DIV       (16'(TDIV)),
        .CYCLE_INIT     (CYC0)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus.master),
        .core_pc            (core_pc),
        .core_insn          (core_insn),
        .core_insn_valid    (core_insn_valid),
        .core_insn_complete (core_insn_complete),
        .core_pc_next       (core_pc_next),
        .core_trap          (core_trap),
        .core_mem_valid     (core_mem_valid),
        .core_mem_addr      (core_mem_addr),
        .core_mem_wdata     (core_mem_wdata),
        .core_mem_wstrb     (core_mem_wstrb),
        .core_mem_ready     (core_mem_ready),
        .core_mem_rdata     (core_mem_rdata),
        .csr_cycle          (csr_cycle),
        .csr_time           (csr_time),
        .csr_instret        (csr_instret),
        .halted             (halted)
    );

    // ------------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    int          n_cyc = 0;   // clock edges seen since reset was released
    logic [31:0] m_pc;
    int          m_instret;
    bit          m_halt;

    always @(posedge clk) begin
        if (reset) n_cyc <= 0;
        else       n_cyc <= n_cyc + 1;
    end

    function automatic logic [63:0] exp_cycle();
`ifdef RV32_SEQ_COUNTERS_EN
        return CYC0 + 64'(n_cyc);
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] exp_time();
`ifdef RV32_SEQ_COUNTERS_EN
        return 64'(n_cyc / TDIV);
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] exp_instret();
`ifdef RV32_SEQ_COUNTERS_EN
        return 64'(m_instret);
`else
        return 64'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One instruction as seen from outside the sequencer.
    typedef struct {
        bit          rst_before;
        logic [31:0] insn;
        int          flen;      // fetch cycles, mem_ready on the last
        bit          has_data;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
        int          dlen;      // data cycles, mem_ready on the last
        int          hold;      // extra cycles before completion
        bit          trap;
        logic [31:0] pc_next;
        logic [31:0] exp_pc;
        bit          exp_halt;
    } vec_t;

    vec_t tbl [9];

    task automatic drive_idle();
        bus.mem_ready      = 1'b0;
        bus.mem_rdata      = 32'd0;
        core_insn_complete = 1'b0;
        core_pc_next       = 32'd0;
        core_trap          = 1'b0;
        core_mem_valid     = 1'b0;
        core_mem_addr      = 32'd0;
        core_mem_wdata     = 32'd0;
        core_mem_wstrb     = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        bus.mem_ready  = 1'b1;
        core_mem_valid = 1'b1;
        #1;
        check("rst_valid",  bus.mem_valid, 0);
        check("rst_instr",  bus.mem_instr, 0);
        check("rst_addr",   bus.mem_addr, 0);
        check("rst_wstrb",  bus.mem_wstrb, 0);
        check("rst_cready", core_mem_ready, 0);
        check("rst_pc",     core_pc, PC0);
        check("rst_insn",   core_insn, 0);
        check("rst_ivalid", core_insn_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_instret", csr_instret, 0);
        check("rst_time",   csr_time, 0);
        @(negedge clk);
        drive_idle();
        reset     = 1'b0;
        m_pc      = PC0;
        m_instret = 0;
        m_halt    = 1'b0;
    endtask

    // Runs one transaction against the model and returns #1 after the edge
    // that ends it.
    task automatic run_insn(input vec_t v);
        int ncyc;
        bit last;
        bit in_d;
        bit dready;
        if (m_pc[1:0] != 2'b00) begin
            @(negedge clk);
            drive_idle();
            bus.mem_ready = 1'b1;
            #1;
            check("mis_valid", bus.mem_valid, 0);
            @(posedge clk);
            #1;
            drive_idle();
            check("mis_valid2", bus.mem_valid, 0);
            m_halt = 1'b1;
            return;
        end
        for (int i = 0; i < v.flen; i++) begin
            @(negedge clk);
            drive_idle();
            bus.mem_ready = (i == v.flen - 1);
            bus.mem_rdata = (i == v.flen - 1) ? v.insn : ~v.insn;
            #1;
            check("f_valid",  bus.mem_valid, 1);
            check("f_instr",  bus.mem_instr, 1);
            check("f_addr",   bus.mem_addr, m_pc);
            check("f_wstrb",  bus.mem_wstrb, 0);
            check("f_ivalid", core_insn_valid, 0);
        end
        if (v.trap) begin
            @(negedge clk);
            drive_idle();
            core_trap          = 1'b1;
            core_insn_complete = 1'b1;
            core_pc_next       = v.pc_next;
            core_mem_valid     = v.has_data;
            core_mem_addr      = v.daddr;
            bus.mem_ready      = 1'b1;
            #1;
            check("t_insn",   core_insn, v.insn);
            check("t_ivalid", core_insn_valid, 1);
            check("t_valid",  bus.mem_valid, 0);
            check("t_cready", core_mem_ready, 0);
            @(posedge clk);
            #1;
            drive_idle();
            m_halt = 1'b1;
            return;
        end
        ncyc = (v.has_data ? v.dlen : 1) + v.hold;
        for (int c = 0; c < ncyc; c++) begin
            last   = (c == ncyc - 1);
            in_d   = v.has_data && (c < v.dlen);
            dready = in_d && (c == v.dlen - 1);
            @(negedge clk);
            drive_idle();
            core_insn_complete = last;
            core_pc_next       = v.pc_next;
            core_mem_valid     = v.has_data;
            core_mem_addr      = v.daddr;
            core_mem_wdata     = v.wdata;
            core_mem_wstrb     = v.wstrb;
            // After the access completes memory keeps answering, so a reissue
            // would be visible on mem_valid.
            bus.mem_ready      = in_d ? dready : v.has_data;
            bus.mem_rdata      = in_d ? v.rdata : ~v.rdata;
            #1;
            if (c == 0) begin
                check("e_insn",   core_insn, v.insn);
                check("e_ivalid", core_insn_valid, 1);
                check("e_pc",     core_pc, m_pc);
            end
            if (in_d) begin
                check("d_valid",  bus.mem_valid, 1);
                check("d_instr",  bus.mem_instr, 0);
                check("d_addr",   bus.mem_addr, v.daddr);
                check("d_wstrb",  bus.mem_wstrb, v.wstrb);
                check("d_wdata",  bus.mem_wdata, v.wdata);
                check("d_cready", core_mem_ready, dready);
                if (dready) check("d_rdata", core_mem_rdata, v.rdata);
            end else if (v.has_data) begin
                check("h_valid",  bus.mem_valid, 0);
                check("h_cready", core_mem_ready, 1);
                check("h_rdata",  core_mem_rdata, v.rdata);
            end else begin
                check("n_valid",  bus.mem_valid, 0);
                check("n_cready", core_mem_ready, 0);
            end
            if (last) begin
                check("c_instret", csr_instret, exp_instret());
                check("c_cycle",   csr_cycle, exp_cycle());
                check("c_time",    csr_time, exp_time());
            end
        end
        @(posedge clk);
        #1;
        drive_idle();
        m_pc = v.pc_next;
        m_instret++;
    endtask

    task automatic post_check(input logic [31:0] exp_pc, input bit exp_halt);
        check("post_pc",   core_pc, exp_pc);
        check("post_halt", halted, exp_halt);
        if (exp_halt) begin
            repeat (3) @(negedge clk);
            #1;
            check("halt_keep",    halted, 1);
            check("halt_valid",   bus.mem_valid, 0);
            check("halt_ivalid",  core_insn_valid, 0);
            check("halt_pc",      core_pc, exp_pc);
            check("halt_instret", csr_instret, exp_instret());
            check("halt_cycle",   csr_cycle, exp_cycle());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        v;
        logic [31:0] r32;
        logic [31:0] e_pc;
        bit          e_halt;
        int          r;

        //               rst  insn           fl data daddr         wdata         rdata         wstrb    dl hd trap pc_next        exp_pc         halt
        tbl[0] = '{1'b1, 32'h0050_0093, 1, 1'b0, 32'h0,        32'h0,        32'h0,        4'h0,    1, 0, 1'b0, 32'h0000_0104, 32'h0000_0104, 1'b0}; // ADDI
        tbl[1] = '{1'b0, 32'h0000_a103, 2, 1'b1, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 4'h0,    3, 0, 1'b0, 32'h0000_0108, 32'h0000_0108, 1'b0}; // LW, 3-cycle data
        tbl[2] = '{1'b0, 32'h0020_a223, 1, 1'b1, 32'h0000_0204, 32'h1234_5678, 32'h0,        4'b1111, 1, 2, 1'b0, 32'h0000_010C, 32'h0000_010C, 1'b0}; // SW, held 2
        tbl[3] = '{1'b0, 32'h0020_8323, 1, 1'b1, 32'h0000_0206, 32'h00AB_0000, 32'h0,        4'b0100, 2, 1, 1'b0, 32'h0000_0110, 32'h0000_0110, 1'b0}; // SB
        tbl[4] = '{1'b0, 32'h0f00_006f, 3, 1'b0, 32'h0,        32'h0,        32'h0,        4'h0,    1, 1, 1'b0, 32'h0000_0200, 32'h0000_0200, 1'b0}; // JAL
        tbl[5] = '{1'b0, 32'h0020_8067, 1, 1'b0, 32'h0,        32'h0,        32'h0,        4'h0,    1, 0, 1'b0, 32'h0000_0302, 32'h0000_0302, 1'b0}; // JALR -> ..10
        tbl[6] = '{1'b0, 32'h0,        1, 1'b0, 32'h0,        32'h0,        32'h0,        4'h0,    1, 0, 1'b0, 32'h0,        32'h0000_0302, 1'b1}; // misaligned fetch
        tbl[7] = '{1'b1, 32'h0000_0000, 1, 1'b0, 32'h0,        32'h0,        32'h0,        4'h0,    1, 0, 1'b1, 32'h0000_0104, 32'h0000_0100, 1'b1}; // illegal -> trap
        tbl[8] = '{1'b1, 32'h0000_a103, 2, 1'b1, 32'h0000_0200, 32'h0,        32'h0,        4'h0,    1, 0, 1'b1, 32'h0000_0104, 32'h0000_0100, 1'b1}; // trap with data req

        reset = 1'b1;
        drive_idle();

        // Directed table
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst_before) do_reset();
            run_insn(tbl[i]);
            post_check(tbl[i].exp_pc, tbl[i].exp_halt);
        end

        // Reset in the middle of a data access: nothing completes, restart at PC0.
        do_reset();
        @(negedge clk);
        drive_idle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_a103;
        #1;
        check("mt_fetch", bus.mem_valid, 1);
        @(negedge clk);
        drive_idle();
        core_mem_valid = 1'b1;
        core_mem_addr  = 32'h0000_0200;
        #1;
        check("mt_dreq",   bus.mem_valid, 1);
        check("mt_dinstr", bus.mem_instr, 0);
        do_reset();
        run_insn(tbl[0]);
        post_check(32'h0000_0104, 1'b0);
        check("mt_instret", csr_instret, exp_instret());

        // Counters: 100 cycles with the fetch stalled.
        do_reset();
        repeat (100) @(negedge clk);
        #1;
        check("cnt_stall_valid", bus.mem_valid, 1);
        check("cnt_stall_addr",  bus.mem_addr, PC0);
        check("cnt_time100",     csr_time, exp_time());
        check("cnt_cycle100",    csr_cycle, exp_cycle());
`ifdef RV32_SEQ_COUNTERS_EN
        check("cnt_time25",      csr_time, 64'd25);
        check("cnt_wrap",        csr_cycle, 64'd99);
`endif

        // Random transactions against the model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if (m_halt) do_reset();
            v.rst_before = 1'b0;
            v.insn       = $urandom;
            v.flen       = $urandom_range(1, 3);
            v.has_data   = 1'($urandom_range(0, 1));
            v.daddr      = $urandom;
            v.wdata      = $urandom;
            v.rdata      = $urandom;
            v.wstrb      = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            v.dlen       = $urandom_range(1, 3);
            v.hold       = $urandom_range(0, 2);
            v.trap       = ($urandom_range(0, 15) == 0);
            r            = $urandom_range(0, 19);
            r32          = $urandom;
            if (r == 0)      v.pc_next = {r32[31:2], 2'b10};
            else if (r < 5)  v.pc_next = {r32[31:2], 2'b00};
            else             v.pc_next = m_pc + 32'd4;
            e_halt = (m_pc[1:0] != 2'b00) || v.trap;
            e_pc   = e_halt ? m_pc : v.pc_next;
            v.exp_pc   = e_pc;
            v.exp_halt = e_halt;
            run_insn(v);
            post_check(v.exp_pc, v.exp_halt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
